// File: rtl/imem_loader_if.sv
// Byte-stream receive handshake plus IMEM byte-write port of the boot loader.
interface imem_loader_if #(
  parameter int AW = 12
);
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, mem_we, mem_waddr, mem_wdata
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, mem_we, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time IMEM loader: parses {LEN_LO, LEN_HI, payload, CSUM} from a byte stream,
// writes the payload to IMEM from address 0 and releases the core only on a good image.
module imem_loader #(
  parameter int MEM_NBYTE      = 4096,
  parameter int AW             = 12,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter bit HOLD_AT_RESET  = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  imem_loader_if.slave   bus,
  output logic           cpu_hold,
  output logic           busy,
  output logic           done,
  output logic [2:0]     err_code,
  output logic [AW:0]    bytes_loaded
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t        state_r;
  state_t        next_s;
  logic [2:0]    next_err_s;
  logic          xfer_s;
  logic          timeout_s;
  logic          launch_s;
  logic          rx_ready_r;
  logic [7:0]    len_lo_r;
  logic [15:0]   len_s;
  logic [AW:0]   len_r;
  logic [AW:0]   addr_r;
  logic [7:0]    acc_r;
  logic [TW-1:0] tmo_r;

  function automatic logic is_busy(input state_t s);
    case (s)
      S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM: is_busy = 1'b1;
      default:                            is_busy = 1'b0;
    endcase
  endfunction

  assign xfer_s    = bus.rx_valid && rx_ready_r;
  assign timeout_s = !xfer_s && (tmo_r == TW'(TIMEOUT_CYCLES - 1));
  assign launch_s  = start && !is_busy(state_r);
  assign len_s     = {bus.rx_data, len_lo_r};

  assign bus.rx_ready  = rx_ready_r;
  assign bus.mem_we    = (state_r == S_DATA) && xfer_s;
  assign bus.mem_waddr = addr_r[AW-1:0];
  assign bus.mem_wdata = bus.rx_data;
  assign bytes_loaded  = addr_r;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state and error-code decode; a transfer always wins over a timeout
  always_comb begin
    next_s     = state_r;
    next_err_s = 3'd0;
    case (state_r)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) next_s = S_LEN_LO;
        else       next_s = state_r;
      end
      S_LEN_LO: begin
        if (xfer_s) begin
          next_s = S_LEN_HI;
        end else if (timeout_s) begin
          next_s     = S_ERR;
          next_err_s = 3'd4;
        end else begin
          next_s = state_r;
        end
      end
      S_LEN_HI: begin
        if (xfer_s) begin
          if ({16'd0, len_s} > 32'(MEM_NBYTE)) begin
            next_s     = S_ERR;
            next_err_s = 3'd1;
          end else if (len_s[1:0] != 2'b00) begin
            next_s     = S_ERR;
            next_err_s = 3'd2;
          end else if (len_s == 16'd0) begin
            next_s = S_CSUM;
          end else begin
            next_s = S_DATA;
          end
        end else if (timeout_s) begin
          next_s     = S_ERR;
          next_err_s = 3'd4;
        end else begin
          next_s = state_r;
        end
      end
      S_DATA: begin
        if (xfer_s) begin
          if ((addr_r + (AW+1)'(1)) == len_r) next_s = S_CSUM;
          else                                next_s = state_r;
        end else if (timeout_s) begin
          next_s     = S_ERR;
          next_err_s = 3'd4;
        end else begin
          next_s = state_r;
        end
      end
      S_CSUM: begin
        if (xfer_s) begin
          if (bus.rx_data == acc_r) begin
            next_s = S_DONE;
          end else begin
            next_s     = S_ERR;
            next_err_s = 3'd3;
          end
        end else if (timeout_s) begin
          next_s     = S_ERR;
          next_err_s = 3'd4;
        end else begin
          next_s = state_r;
        end
      end
      default: begin
        next_s     = S_IDLE;
        next_err_s = 3'd0;
      end
    endcase
  end

  // Datapath, status flags and idle-cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ready_r <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_code   <= 3'd0;
      cpu_hold   <= HOLD_AT_RESET;
      addr_r     <= '0;
      acc_r      <= 8'd0;
      tmo_r      <= '0;
      len_lo_r   <= 8'd0;
      len_r      <= '0;
    end else begin
      rx_ready_r <= is_busy(next_s);
      busy       <= is_busy(next_s);
      if (launch_s) begin
        done     <= 1'b0;
        err_code <= 3'd0;
        cpu_hold <= 1'b1;
        addr_r   <= '0;
        acc_r    <= 8'd0;
        tmo_r    <= '0;
      end else begin
        if (bus.mem_we) begin
          addr_r <= addr_r + (AW+1)'(1);
          acc_r  <= acc_r + bus.rx_data;
        end
        if (xfer_s || !is_busy(state_r)) tmo_r <= '0;
        else                             tmo_r <= tmo_r + TW'(1);
        if (state_r == S_CSUM && next_s == S_DONE) begin
          done     <= 1'b1;
          cpu_hold <= 1'b0;
        end
        if (is_busy(state_r) && next_s == S_ERR) err_code <= next_err_s;
      end
      if (state_r == S_LEN_LO && xfer_s) len_lo_r <= bus.rx_data;
      // Length is only used once it has passed the range check, so AW+1 bits suffice
      if (state_r == S_LEN_HI && xfer_s) len_r <= len_s[AW:0];
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table, random frames against a frame-level model,
// and hand-written timeout / mid-frame reset sequences.
module tb_imem_loader;
  localparam int AW  = 12;
  localparam int MEM = 4096;
  localparam int TMO = 50;

  logic          clk;
  logic          rst;
  logic          start;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic [2:0]    err_code;
  logic [AW:0]   bytes_loaded;

  imem_loader_if #(.AW(AW)) bus ();

  imem_loader #(
    .MEM_NBYTE(MEM), .AW(AW), .TIMEOUT_CYCLES(TMO), .HOLD_AT_RESET(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .err_code(err_code), .bytes_loaded(bytes_loaded)
  );

  int checks   = 0;
  int failures = 0;

  logic [AW-1:0] wa_q[$];
  logic [7:0]    wd_q[$];
  logic [7:0]    pay_q[$];

  typedef struct {
    logic [15:0] len;
    int          csum_off;
    logic [2:0]  exp_err;
    bit          exp_done;
    int          vprob;
  } vec_t;

  vec_t vecs[10];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every IMEM write seen on the port
  always @(negedge clk) begin
    if (bus.mem_we) begin
      wa_q.push_back(bus.mem_waddr);
      wd_q.push_back(bus.mem_wdata);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish before 90000 cycles");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit len_ok(input logic [15:0] len);
    return (int'(len) <= MEM) && (len % 4 == 0);
  endfunction

  function automatic logic [2:0] model_err(input logic [15:0] len, input int csum_off);
    if (int'(len) > MEM)       return 3'd1;
    else if (len % 4 != 0)     return 3'd2;
    else if (csum_off % 256)   return 3'd3;
    else                       return 3'd0;
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Offer one byte until accepted; rx_valid toggles randomly but never idles past 8 cycles
  task automatic send_byte(input logic [7:0] b, input int vprob);
    int idle = 0;
    bit acc  = 1'b0;
    bus.rx_data = b;
    for (int c = 0; c < 200 && !acc; c++) begin
      bus.rx_valid = (idle >= 8) || ($urandom_range(0, 99) < vprob);
      @(negedge clk);
      if (bus.rx_valid && bus.rx_ready) acc = 1'b1;
      else if (!bus.rx_valid)           idle++;
      @(posedge clk); #1;
    end
    bus.rx_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_byte: got no accept expected accept of byte %0d", b);
    end
  endtask

  task automatic check_writes(input string name, input int n);
    chk({name, "_wr_count"}, wa_q.size(), n);
    for (int i = 0; i < n && i < wa_q.size(); i++) begin
      chk({name, "_wr_addr"}, int'(wa_q[i]), i);
      chk({name, "_wr_data"}, int'(wd_q[i]), int'(pay_q[i]));
    end
  endtask

  task automatic run_frame(input string name, input logic [15:0] len, input int csum_off,
                           input int vprob, input logic [2:0] exp_err, input bit exp_done);
    logic [7:0] sum;
    int nexp;
    sum = 8'd0;
    for (int i = 0; i < pay_q.size(); i++) sum = sum + pay_q[i];
    wa_q.delete();
    wd_q.delete();
    pulse_start();
    send_byte(len[7:0], vprob);
    send_byte(len[15:8], vprob);
    if (len_ok(len)) begin
      for (int i = 0; i < int'(len); i++) send_byte(pay_q[i], vprob);
      send_byte(sum + 8'(csum_off), vprob);
    end
    nexp = len_ok(len) ? int'(len) : 0;
    @(negedge clk);
    chk({name, "_err_code"}, err_code, exp_err);
    chk({name, "_done"}, done, exp_done);
    chk({name, "_cpu_hold"}, cpu_hold, !exp_done);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_rx_ready"}, bus.rx_ready, 0);
    chk({name, "_bytes_loaded"}, bytes_loaded, nexp);
    check_writes(name, nexp);
  endtask

  task automatic fill_payload(input int n, input bit nominal);
    logic [7:0] nom [8];
    nom = '{8'h93, 8'h00, 8'h00, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00};
    pay_q.delete();
    for (int i = 0; i < n; i++) pay_q.push_back(nominal ? nom[i % 8] : 8'($urandom_range(0, 255)));
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'd0;

    vecs[0] = '{16'd8,      0, 3'd0, 1'b1, 100};
    vecs[1] = '{16'd8,      0, 3'd0, 1'b1, 40};
    vecs[2] = '{16'd0,      0, 3'd0, 1'b1, 100};
    vecs[3] = '{16'h1004,   0, 3'd1, 1'b0, 100};
    vecs[4] = '{16'd6,      0, 3'd2, 1'b0, 100};
    vecs[5] = '{16'd4,      1, 3'd3, 1'b0, 70};
    vecs[6] = '{16'd4,      0, 3'd0, 1'b1, 70};
    vecs[7] = '{16'd4097,   0, 3'd1, 1'b0, 100};
    vecs[8] = '{16'd4094,   0, 3'd2, 1'b0, 100};
    vecs[9] = '{16'd4096,   0, 3'd0, 1'b1, 100};

    #3;
    chk("rst_cpu_hold", cpu_hold, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_rx_ready", bus.rx_ready, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_bytes_loaded", bytes_loaded, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("idle_cpu_hold", cpu_hold, 1);
    chk("idle_rx_ready", bus.rx_ready, 0);
    chk("idle_busy", busy, 0);

    for (int v = 0; v < 10; v++) begin
      fill_payload(len_ok(vecs[v].len) ? int'(vecs[v].len) : 0, v < 2);
      run_frame($sformatf("vec%0d", v), vecs[v].len, vecs[v].csum_off, vecs[v].vprob,
                vecs[v].exp_err, vecs[v].exp_done);
    end

    for (int r = 0; r < 8; r++) begin
      logic [15:0] len;
      int off;
      logic [2:0] e;
      if ($urandom_range(0, 3) == 0) len = 16'($urandom_range(1, 5000));
      else                           len = 16'(4 * $urandom_range(1, 16));
      off = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 255) : 0;
      e = model_err(len, off);
      fill_payload(len_ok(len) ? int'(len) : 0, 1'b0);
      run_frame($sformatf("rnd%0d", r), len, off, $urandom_range(30, 100), e, e == 3'd0);
    end

    // Timeout after 2 payload bytes, with a start pulse while busy that must be ignored
    fill_payload(8, 1'b0);
    wa_q.delete();
    wd_q.delete();
    pulse_start();
    send_byte(8'h08, 100);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    send_byte(8'h00, 100);
    send_byte(pay_q[0], 100);
    send_byte(pay_q[1], 100);
    repeat (TMO - 1) @(posedge clk);
    @(negedge clk);
    chk("tmo_before_err", err_code, 0);
    chk("tmo_before_busy", busy, 1);
    @(posedge clk);
    @(negedge clk);
    chk("tmo_err_code", err_code, 4);
    chk("tmo_busy", busy, 0);
    chk("tmo_cpu_hold", cpu_hold, 1);
    chk("tmo_done", done, 0);
    chk("tmo_bytes_loaded", bytes_loaded, 2);
    check_writes("tmo", 2);

    // Asynchronous reset in the middle of the payload
    fill_payload(8, 1'b1);
    pulse_start();
    send_byte(8'h08, 100);
    send_byte(8'h00, 100);
    for (int i = 0; i < 3; i++) send_byte(pay_q[i], 100);
    bus.rx_valid = 1'b1;
    bus.rx_data  = pay_q[3];
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rx_ready", bus.rx_ready, 0);
    chk("mid_rst_mem_we", bus.mem_we, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err_code", err_code, 0);
    chk("mid_rst_bytes_loaded", bytes_loaded, 0);
    chk("mid_rst_cpu_hold", cpu_hold, 1);
    bus.rx_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    run_frame("after_rst", 16'd8, 0, 100, 3'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time controller that fills the byte-addressable instruction memory from a byte stream (UART/debug bridge) before the core runs.
- Parses a framed image (length, payload, checksum) and issues byte writes to the IMEM write port.
- Holds the core in stall/reset until a valid image is loaded, and reports done or error status.

Parameters:
- MEM_NBYTE, 4096, IMEM size in bytes. Must be a power of two.
- AW, 12, IMEM byte-address width. Equals log2(MEM_NBYTE).
- TIMEOUT_CYCLES, 1000000, maximum idle cycles between received bytes while a frame is in progress.
- HOLD_AT_RESET, 1, reset value of cpu_hold.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  single-cycle pulse that begins reception of a frame
- rx_valid  input  1  rx_data is valid this cycle
- rx_data  input  8  received byte
- rx_ready  output  1  loader accepts rx_data this cycle
- mem_we  output  1  IMEM byte write enable
- mem_waddr  output  AW  IMEM byte address
- mem_wdata  output  8  IMEM write byte
- cpu_hold  output  1  stalls/resets the core while high
- busy  output  1  a frame is in progress
- done  output  1  last frame loaded successfully; sticky
- err_code  output  3  0 none, 1 length out of range, 2 length misaligned, 3 checksum mismatch, 4 timeout; sticky
- bytes_loaded  output  AW+1  payload bytes written in the current or last frame

Behaviour:
- Handshake: a byte transfers in any cycle with rx_valid && rx_ready. rx_data must be held stable while rx_valid=1 && rx_ready=0.
- Frame format, all fields little-endian:
  - LEN_LO, LEN_HI: payload length L, in bytes.
  - L payload bytes, stored at address 0 upward.
  - CSUM: sum of the payload bytes mod 256.
- States: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
- rx_ready=1 only in LEN_LO, LEN_HI, DATA and CSUM. It is a registered state decode.
- IDLE, DONE, ERR:
  - start goes to LEN_LO.
  - On entry, clear done, err_code, bytes_loaded, the address counter and the checksum accumulator, and set cpu_hold=1.
- LEN_LO, then LEN_HI: latch L. After the LEN_HI transfer, the next state is:
  - ERR (code 1) if L > MEM_NBYTE;
  - else ERR (code 2) if L[1:0] != 0;
  - else CSUM if L = 0;
  - else DATA.
- DATA: each transfer does the following in the same cycle:
  - mem_we=1, mem_waddr=address counter, mem_wdata=rx_data. mem_we is combinational; it is 0 in every other case.
  - On the clock edge, increment the address counter and bytes_loaded, and add the byte into the accumulator.
  - After the L-th byte, go to CSUM.
- CSUM: on transfer, go to DONE if the byte equals the accumulator, else ERR (code 3).
- DONE: done=1 and cpu_hold=0 from the cycle after the CSUM transfer.
- ERR: cpu_hold stays 1; err_code holds its value.
- Timeout:
  - A counter clears on every transfer and on entry to LEN_LO.
  - It increments each cycle in LEN_LO, LEN_HI, DATA and CSUM.
  - On reaching TIMEOUT_CYCLES, go to ERR (code 4). A transfer in that same cycle takes priority and clears the counter.
- start is ignored while busy (states LEN_LO to CSUM). busy=1 exactly in those states.
- Writes already made before an error are not undone.
- Address arithmetic: the counter is AW+1 bits and cannot wrap, because L <= MEM_NBYTE. mem_waddr is the low AW bits of the counter.
- Reset, including mid-frame, takes effect immediately and asynchronously:
  - state=IDLE, rx_ready=0, mem_we=0, busy=0, done=0, err_code=0, bytes_loaded=0;
  - cpu_hold=HOLD_AT_RESET.
- Reset-exit from IDLE with no start: cpu_hold stays at HOLD_AT_RESET indefinitely.

Test Plan:
- Nominal load: start; frame 08 00, bytes 93 00 00 00 13 01 50 00, csum 0xF7. Required:
  - 8 writes at addresses 0..7 with matching data;
  - done=1, cpu_hold=0, bytes_loaded=8, err_code=0.
- Backpressure and gaps: same frame with rx_valid toggling randomly, idle gaps below TIMEOUT_CYCLES. Required: identical writes, no duplicated or dropped bytes, done=1.
- Length errors:
  - L=0x1004 gives err_code=1 with no writes.
  - L=6 gives err_code=2 with no writes.
  - In both cases cpu_hold=1 and rx_ready=0 afterwards.
- Bad checksum: valid 4-byte frame with csum off by one. Required: 4 writes occur, then err_code=3, done=0, cpu_hold=1.
  - A following start with a good frame gives done=1 and err_code cleared.
- Timeout: TIMEOUT_CYCLES=50, stop sending after 2 payload bytes. Required: err_code=4 on cycle 50 after the last transfer.
  - A start pulse while busy, earlier in the same run, is ignored.
- Reset mid-DATA: assert rst after 3 payload bytes. Required:
  - outputs go to reset values immediately;
  - a new start plus a full frame loads correctly from address 0.
